// File: rtl/i2s_tx_scheduler.sv
// rtl/i2s_tx_scheduler.sv - I2S frame scheduler: pops sample pairs, issues serializer loads, bit tick and word select
module i2s_tx_scheduler #(
  parameter int CLK_DIV    = 4,
  parameter int UNDERRUN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [3:0]            cfg_size,
  input  logic                  fifo_empty,
  input  logic [31:0]           fifo_left,
  input  logic [31:0]           fifo_right,
  output logic                  fifo_rd,
  output logic                  ser_load,
  output logic [31:0]           ser_left,
  output logic [31:0]           ser_right,
  output logic [3:0]            ser_size,
  output logic                  bit_tick,
  output logic                  ws,
  output logic                  active,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   div_cnt;
  logic [5:0]         bit_cnt;
  logic [5:0]         frame_w;
  logic [6:0]         last_bit;
  logic               pend_valid;
  logic [31:0]        pend_l, pend_r;
  logic [3:0]         size_norm;
  logic               in_run, div_last, frame_start, frame_end, fill;

  always_comb begin
    size_norm = 4'd3;
    case (cfg_size)
      4'd0, 4'd1, 4'd4: size_norm = cfg_size;
      default:          size_norm = 4'd3;
    endcase
  end

  // ser_size holds the normalized code latched at frame start, so it fixes W for the frame
  always_comb begin
    frame_w = 6'd16;
    case (ser_size)
      4'd0:    frame_w = 6'd8;
      4'd1:    frame_w = 6'd12;
      4'd4:    frame_w = 6'd32;
      default: frame_w = 6'd16;
    endcase
  end

  assign last_bit    = {frame_w, 1'b0} - 7'd1;
  assign in_run      = (state == RUN);
  assign div_last    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign frame_start = in_run && (div_cnt == '0) && (bit_cnt == 6'd0);
  assign bit_tick    = in_run && div_last;
  assign frame_end   = bit_tick && ({1'b0, bit_cnt} == last_bit);
  assign ws          = in_run && (bit_cnt >= frame_w);
  assign fill        = ((state == PRIME) || in_run) && !pend_valid && !fifo_empty;
  assign fifo_rd     = fill;
  assign ser_load    = frame_start;
  assign active      = in_run;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = PRIME;
      PRIME:   state_next = RUN;
      RUN:     if (frame_end && !enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      bit_cnt      <= 6'd0;
      pend_valid   <= 1'b0;
      pend_l       <= 32'd0;
      pend_r       <= 32'd0;
      ser_left     <= 32'd0;
      ser_right    <= 32'd0;
      ser_size     <= 4'd0;
      underrun_cnt <= '0;
    end else begin
      if (fill) begin
        pend_valid <= 1'b1;
        pend_l     <= fifo_left;
        pend_r     <= fifo_right;
      end
      // fill needs !pend_valid and the load only clears a valid entry, so they never collide
      if (frame_start) begin
        ser_size <= size_norm;
        if (pend_valid) begin
          ser_left   <= pend_l;
          ser_right  <= pend_r;
          pend_valid <= 1'b0;
        end else begin
          ser_left  <= 32'd0;
          ser_right <= 32'd0;
          if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
        end
      end
      if (in_run) begin
        if (div_last) begin
          div_cnt <= '0;
          bit_cnt <= frame_end ? 6'd0 : bit_cnt + 6'd1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else begin
        div_cnt <= '0;
        bit_cnt <= 6'd0;
      end
    end
  end

endmodule
